fwd_scoreboard: RTL and testbench

//  Parametrised operand-forwarding and hazard scoreboard for the pipelined core.

---
 rtl/fwd_scoreboard_pkg.sv | 28 ++
 rtl/fwd_scoreboard_if.sv | 39 +++
 rtl/fwd_src_match.sv | 47 ++++
 rtl/fwd_scoreboard.sv | 103 ++++++++++
 tb/tb_fwd_scoreboard.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg
//  Shared constants for the operand-forwarding scoreboard: default widths,
//  ALU opcode encoding and the fwd_sel field width helper.
//  No ports.
package fwd_scoreboard_pkg;

   localparam int REGAW_DEF     = 4;
   localparam int ALUAW_DEF     = 4;
   localparam int DEPTH_DEF     = 3;
   localparam int NSRC_DEF      = 3;
   localparam int LOAD_LAT_DEF  = 1;
   localparam int NOFWD_REG_DEF = 15;

   // Data-processing opcode encoding. TST/TEQ/CMP/CMN only set flags and
   // therefore never produce a register result.
   typedef enum logic [3:0] {
      OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
      OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
      OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
      OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
   } alu_op_e;

   // Width of one fwd_sel field: encodes 0 (regfile) .. depth (oldest slot).
   function automatic int sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if
//  Decode <-> scoreboard bundle.
//  master (decode):     drives issue_*, src_reg, src_used, flush;
//                       receives fwd_sel, stall, inflight.
//  slave (scoreboard):  the reverse.
//  src_reg field i = bits [i*REGAW +: REGAW]; fwd_sel field i = bits [i*SELW +: SELW].
interface fwd_scoreboard_if #(
   parameter int REGAW = fwd_scoreboard_pkg::REGAW_DEF,
   parameter int ALUAW = fwd_scoreboard_pkg::ALUAW_DEF,
   parameter int DEPTH = fwd_scoreboard_pkg::DEPTH_DEF,
   parameter int NSRC  = fwd_scoreboard_pkg::NSRC_DEF
);
   localparam int SELW = fwd_scoreboard_pkg::sel_w(DEPTH);

   logic                   issue_valid;
   logic [ALUAW-1:0]       issue_opcode;
   logic                   issue_wr;
   logic                   issue_load;
   logic [REGAW-1:0]       issue_dest;
   logic [NSRC*REGAW-1:0]  src_reg;
   logic [NSRC-1:0]        src_used;
   logic                   flush;
   logic [NSRC*SELW-1:0]   fwd_sel;
   logic                   stall;
   logic [SELW-1:0]        inflight;

   modport master (
      output issue_valid, issue_opcode, issue_wr, issue_load, issue_dest,
             src_reg, src_used, flush,
      input  fwd_sel, stall, inflight
   );

   modport slave (
      input  issue_valid, issue_opcode, issue_wr, issue_load, issue_dest,
             src_reg, src_used, flush,
      output fwd_sel, stall, inflight
   );

endinterface

// File: rtl/fwd_src_match.sv
// fwd_src_match
//  Per-source priority match against the in-flight slots.
//  Ports:
//   src_reg_i    source register of this operand
//   src_used_i   operand is real
//   slot_vld_i   slot valids, bit 0 = slot 1 (youngest)
//   slot_dest_i  slot destination registers
//   slot_load_i  slot is a load
//   fwd_sel_o    0 = regfile, k = forward from slot k
//   load_use_o   winning producer is a load whose data is not ready yet
module fwd_src_match #(
   parameter int REGAW     = 4,
   parameter int DEPTH     = 3,
   parameter int LOAD_LAT  = 1,
   parameter int NOFWD_REG = 15,
   parameter int SELW      = 2
) (
   input  logic [REGAW-1:0]            src_reg_i,
   input  logic                        src_used_i,
   input  logic [DEPTH-1:0]            slot_vld_i,
   input  logic [DEPTH-1:0][REGAW-1:0] slot_dest_i,
   input  logic [DEPTH-1:0]            slot_load_i,
   output logic [SELW-1:0]             fwd_sel_o,
   output logic                        load_use_o
);
   logic             chk;
   logic [SELW-1:0]  win;
   logic             win_ld;

   assign chk = src_used_i & (src_reg_i != REGAW'(NOFWD_REG));

   // Scan oldest to youngest so the youngest hit overrides.
   always_comb begin
      win    = '0;
      win_ld = 1'b0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (chk && slot_vld_i[k] && (slot_dest_i[k] == src_reg_i)) begin
            win    = SELW'(k + 1);
            win_ld = slot_load_i[k] && ((k + 1) <= LOAD_LAT);
         end
      end
   end

   assign load_use_o = win_ld;
   assign fwd_sel_o  = win_ld ? '0 : win;

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//  Operand-forwarding and load-use hazard scoreboard. Tracks the destination
//  of the last DEPTH issued instructions in a shift pipeline (slot 1 = EX ..
//  slot DEPTH = WB) and, per decode source operand, selects the youngest
//  in-flight producer or the register file.
//  Ports:
//   clk     core clock
//   nreset  async active-low reset, clears all slots
//   sb      scoreboard side of fwd_scoreboard_if (issue/src/flush in,
//           fwd_sel/stall/inflight out, all outputs combinational)
module fwd_scoreboard #(
   parameter int REGAW     = fwd_scoreboard_pkg::REGAW_DEF,
   parameter int ALUAW     = fwd_scoreboard_pkg::ALUAW_DEF,
   parameter int DEPTH     = fwd_scoreboard_pkg::DEPTH_DEF,
   parameter int NSRC      = fwd_scoreboard_pkg::NSRC_DEF,
   parameter int LOAD_LAT  = fwd_scoreboard_pkg::LOAD_LAT_DEF,
   parameter int NOFWD_REG = fwd_scoreboard_pkg::NOFWD_REG_DEF
) (
   input  logic             clk,
   input  logic             nreset,
   fwd_scoreboard_if.slave  sb
);
   import fwd_scoreboard_pkg::*;

   localparam int SELW = sel_w(DEPTH);

   // Slot state, index 0 = slot 1 (EX), index DEPTH-1 = slot DEPTH (WB).
   logic [DEPTH-1:0]            vld_q, vld_d;
   logic [DEPTH-1:0][REGAW-1:0] dest_q, dest_d;
   logic [DEPTH-1:0]            load_q, load_d;

   logic [NSRC-1:0]             load_use;
   logic [NSRC-1:0][SELW-1:0]   sel;
   logic                        is_cmp;
   logic                        stall;
   logic [SELW-1:0]             cnt;

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      fwd_src_match #(
         .REGAW     (REGAW),
         .DEPTH     (DEPTH),
         .LOAD_LAT  (LOAD_LAT),
         .NOFWD_REG (NOFWD_REG),
         .SELW      (SELW)
      ) u_match (
         .src_reg_i   (sb.src_reg[g*REGAW +: REGAW]),
         .src_used_i  (sb.src_used[g]),
         .slot_vld_i  (vld_q),
         .slot_dest_i (dest_q),
         .slot_load_i (load_q),
         .fwd_sel_o   (sel[g]),
         .load_use_o  (load_use[g])
      );
   end

   assign sb.fwd_sel = sel;

   // Flush wins over any hazard: the decode instruction is dead anyway.
   assign stall    = sb.issue_valid & (|load_use) & ~sb.flush;
   assign sb.stall = stall;

   assign is_cmp = (sb.issue_opcode == ALUAW'(OP_TST)) ||
                   (sb.issue_opcode == ALUAW'(OP_TEQ)) ||
                   (sb.issue_opcode == ALUAW'(OP_CMP)) ||
                   (sb.issue_opcode == ALUAW'(OP_CMN));

   always_comb begin
      vld_d     = '0;
      dest_d    = dest_q;
      load_d    = load_q;
      // A stalled or non-producing issue leaves a bubble in slot 1.
      vld_d[0]  = sb.issue_valid & sb.issue_wr & ~stall & ~sb.flush & ~is_cmp;
      dest_d[0] = sb.issue_dest;
      load_d[0] = sb.issue_load;
      // Older slots keep draining even while decode is stalled.
      for (int k = 1; k < DEPTH; k++) begin
         vld_d[k]  = vld_q[k-1] & ~sb.flush;
         dest_d[k] = dest_q[k-1];
         load_d[k] = load_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         vld_q  <= '0;
         dest_q <= '0;
         load_q <= '0;
      end else begin
         vld_q  <= vld_d;
         dest_q <= dest_d;
         load_q <= load_d;
      end
   end

   // Popcount fits SELW by construction, so it cannot wrap.
   always_comb begin
      cnt = '0;
      for (int k = 0; k < DEPTH; k++) cnt = cnt + SELW'(vld_q[k]);
   end

   assign sb.inflight = cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;
   import fwd_scoreboard_pkg::*;

   localparam int REGAW = 4;
   localparam int ALUAW = 4;
   localparam int DEPTH = 3;
   localparam int NSRC  = 3;
   localparam int SELW  = 2;

   logic clk;
   logic nreset;
   int   nchecks;
   int   nerrors;

   fwd_scoreboard_if #(.REGAW(REGAW), .ALUAW(ALUAW), .DEPTH(DEPTH), .NSRC(NSRC)) sb_if ();

   fwd_scoreboard #(
      .REGAW(REGAW), .ALUAW(ALUAW), .DEPTH(DEPTH), .NSRC(NSRC),
      .LOAD_LAT(1), .NOFWD_REG(15)
   ) dut (
      .clk    (clk),
      .nreset (nreset),
      .sb     (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fsel(input int i);
      logic [NSRC*SELW-1:0] v;
      v = sb_if.fwd_sel;
      return {6'd0, v[i*SELW +: SELW]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input logic v, input logic [3:0] op, input logic wr,
                            input logic ld, input logic [3:0] dst);
      sb_if.issue_valid  = v;
      sb_if.issue_opcode = op;
      sb_if.issue_wr     = wr;
      sb_if.issue_load   = ld;
      sb_if.issue_dest   = dst;
   endtask

   task automatic set_src(input logic [3:0] r0, input logic [3:0] r1,
                          input logic [3:0] r2, input logic [2:0] used);
      sb_if.src_reg  = {r2, r1, r0};
      sb_if.src_used = used;
   endtask

   task automatic idle();
      set_issue(1'b0, OP_AND, 1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      nchecks = 0;
      nerrors = 0;
      nreset  = 1'b0;
      sb_if.flush = 1'b0;
      idle();
      set_src(4'd0, 4'd0, 4'd0, 3'b000);

      // Reset held with random activity on every input.
      repeat (4) begin
         sb_if.issue_valid  = 1'($urandom);
         sb_if.issue_opcode = 4'($urandom);
         sb_if.issue_wr     = 1'($urandom);
         sb_if.issue_load   = 1'($urandom);
         sb_if.issue_dest   = 4'($urandom);
         sb_if.src_reg      = 12'($urandom);
         sb_if.src_used     = 3'($urandom);
         sb_if.flush        = 1'($urandom);
         @(posedge clk);
         #2;
         chk("rst_fwd", {2'd0, sb_if.fwd_sel}, 8'd0);
         chk("rst_stall", {7'd0, sb_if.stall}, 8'd0);
         chk("rst_inflight", {6'd0, sb_if.inflight}, 8'd0);
      end
      idle();
      sb_if.flush = 1'b0;
      set_src(4'd1, 4'd2, 4'd3, 3'b111);
      nreset = 1'b1;
      tick();
      chk("post_rst_fwd", {2'd0, sb_if.fwd_sel}, 8'd0);
      chk("post_rst_inflight", {6'd0, sb_if.inflight}, 8'd0);

      // ADD r1 walks through slots 1..3 then retires.
      set_issue(1'b1, OP_ADD, 1'b1, 1'b0, 4'd1);
      set_src(4'd0, 4'd0, 4'd0, 3'b000);
      tick();
      idle();
      set_src(4'd1, 4'd0, 4'd0, 3'b001);
      #1;
      chk("add_slot1", fsel(0), 8'd1);
      chk("add_inflight", {6'd0, sb_if.inflight}, 8'd1);
      tick();
      chk("add_slot2", fsel(0), 8'd2);
      tick();
      chk("add_slot3", fsel(0), 8'd3);
      tick();
      chk("add_retired", fsel(0), 8'd0);
      chk("add_retired_inflight", {6'd0, sb_if.inflight}, 8'd0);

      // CMP never produces; the following ADD does.
      set_issue(1'b1, OP_CMP, 1'b1, 1'b0, 4'd1);
      tick();
      set_issue(1'b1, OP_ADD, 1'b1, 1'b0, 4'd1);
      #1;
      chk("cmp_fwd", fsel(0), 8'd0);
      chk("cmp_inflight", {6'd0, sb_if.inflight}, 8'd0);
      tick();
      idle();
      #1;
      chk("cmp_add_fwd", fsel(0), 8'd1);
      chk("cmp_add_inflight", {6'd0, sb_if.inflight}, 8'd1);
      tick(); tick(); tick();
      chk("cmp_drain", {6'd0, sb_if.inflight}, 8'd0);

      // LDR r2 then a consumer: one stall cycle, then forward from slot 2.
      set_issue(1'b1, OP_MOV, 1'b1, 1'b1, 4'd2);
      set_src(4'd0, 4'd0, 4'd0, 3'b000);
      tick();
      set_issue(1'b0, OP_ADD, 1'b1, 1'b0, 4'd4);
      set_src(4'd2, 4'd0, 4'd0, 3'b001);
      #1;
      chk("ldu_novalid_stall", {7'd0, sb_if.stall}, 8'd0);
      chk("ldu_novalid_fwd", fsel(0), 8'd0);
      sb_if.issue_valid = 1'b1;
      #1;
      chk("ldu_stall", {7'd0, sb_if.stall}, 8'd1);
      chk("ldu_fwd", fsel(0), 8'd0);
      chk("ldu_inflight", {6'd0, sb_if.inflight}, 8'd1);
      tick();
      chk("ldu_after_stall", {7'd0, sb_if.stall}, 8'd0);
      chk("ldu_after_fwd", fsel(0), 8'd2);
      chk("ldu_bubble_inflight", {6'd0, sb_if.inflight}, 8'd1);
      tick();
      idle();
      set_src(4'd0, 4'd0, 4'd0, 3'b000);
      #1;
      chk("ldu_consumer_in", {6'd0, sb_if.inflight}, 8'd2);
      tick(); tick(); tick();
      chk("ldu_drain", {6'd0, sb_if.inflight}, 8'd0);

      // ADD r3, SUB r3: youngest wins; r15 is never forwarded.
      set_issue(1'b1, OP_ADD, 1'b1, 1'b0, 4'd3);
      tick();
      set_issue(1'b1, OP_SUB, 1'b1, 1'b0, 4'd3);
      tick();
      set_issue(1'b1, OP_MOV, 1'b1, 1'b0, 4'd15);
      set_src(4'd3, 4'd15, 4'd3, 3'b011);
      #1;
      chk("young_fwd", fsel(0), 8'd1);
      chk("young_unused", fsel(2), 8'd0);
      chk("young_inflight", {6'd0, sb_if.inflight}, 8'd2);
      tick();
      idle();
      #1;
      chk("young_fwd2", fsel(0), 8'd2);
      chk("pc_nofwd", fsel(1), 8'd0);
      chk("full_inflight", {6'd0, sb_if.inflight}, 8'd3);

      // Flush with full pipe and a simultaneous issue.
      set_issue(1'b1, OP_ADD, 1'b1, 1'b0, 4'd5);
      set_src(4'd5, 4'd3, 4'd15, 3'b111);
      sb_if.flush = 1'b1;
      #1;
      chk("preflush_fwd", fsel(1), 8'd2);
      tick();
      sb_if.flush = 1'b0;
      idle();
      #1;
      chk("flush_fwd", {2'd0, sb_if.fwd_sel}, 8'd0);
      chk("flush_inflight", {6'd0, sb_if.inflight}, 8'd0);

      // Load-use stall: flush masks it, async reset clears it at once.
      set_issue(1'b1, OP_MOV, 1'b1, 1'b1, 4'd6);
      set_src(4'd0, 4'd0, 4'd0, 3'b000);
      tick();
      set_issue(1'b1, OP_ADD, 1'b1, 1'b0, 4'd7);
      set_src(4'd6, 4'd0, 4'd0, 3'b001);
      #1;
      chk("mid_stall", {7'd0, sb_if.stall}, 8'd1);
      sb_if.flush = 1'b1;
      #1;
      chk("flush_masks_stall", {7'd0, sb_if.stall}, 8'd0);
      sb_if.flush = 1'b0;
      #1;
      chk("stall_back", {7'd0, sb_if.stall}, 8'd1);
      nreset = 1'b0;
      #1;
      chk("async_rst_stall", {7'd0, sb_if.stall}, 8'd0);
      chk("async_rst_inflight", {6'd0, sb_if.inflight}, 8'd0);
      nreset = 1'b1;
      idle();
      tick();
      chk("rel_fwd", fsel(0), 8'd0);
      chk("rel_inflight", {6'd0, sb_if.inflight}, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
